// File: rtl/preg_free_list.sv
// Circular free list of physical register tags: rename pops from the head, commit
// pushes stale tags at the tail, per-branch head checkpoints allow one-cycle rollback.
module preg_free_list #(
  parameter  int NUM_PREGS = 128,
  parameter  int NUM_AREGS = 32,
  parameter  int NUM_CKPT  = 4,
  localparam int TW        = $clog2(NUM_PREGS),
  localparam int CW        = $clog2(NUM_CKPT),
  localparam int DEPTH     = NUM_PREGS - NUM_AREGS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_req_in,
  output logic [TW-1:0] alloc_tag_out,
  output logic          alloc_ok_out,
  output logic          empty_out,
  output logic [TW-1:0] free_count_out,
  input  logic          release_valid_in,
  input  logic [TW-1:0] release_tag_in,
  input  logic          ckpt_valid_in,
  input  logic [CW-1:0] ckpt_id_in,
  input  logic          mispredict,
  input  logic [CW-1:0] mispredict_id_in
);

  typedef struct packed {
    logic          wrap;
    logic [TW-1:0] ptr;
  } ptr_t;

  logic [TW-1:0] mem_q [DEPTH];
  ptr_t          rd_q, rd_d, rd_adv;
  ptr_t          wr_q, wr_d;
  ptr_t          ckpt_q [NUM_CKPT];
  logic          full;
  logic          rel_do;

  function automatic ptr_t incr(input ptr_t p);
    ptr_t r;
    if (p.ptr == TW'(DEPTH - 1)) begin
      r.ptr  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.ptr  = p.ptr + 1'b1;
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  always_comb begin
    full           = (rd_q.ptr == wr_q.ptr) && (rd_q.wrap != wr_q.wrap);
    free_count_out = (rd_q.wrap == wr_q.wrap) ? (wr_q.ptr - rd_q.ptr)
                                              : (TW'(DEPTH) - rd_q.ptr + wr_q.ptr);
    empty_out      = (free_count_out == '0);
    alloc_ok_out   = alloc_req_in && !empty_out && !mispredict;
    alloc_tag_out  = mem_q[rd_q.ptr];
    rel_do         = release_valid_in && (release_tag_in != '0);

    // Checkpoints capture the head after this cycle's pop; rollback overrides both.
    rd_adv = alloc_ok_out ? incr(rd_q) : rd_q;
    rd_d   = mispredict ? ckpt_q[mispredict_id_in] : rd_adv;
    wr_d   = rel_do ? incr(wr_q) : wr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TW'(NUM_AREGS + i);
      end
      rd_q <= '0;
      wr_q <= '{wrap: 1'b1, ptr: '0};
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt_q[c] <= '0;
      end
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      if (rel_do) begin
        mem_q[wr_q.ptr] <= release_tag_in;
      end
      if (ckpt_valid_in && !mispredict) begin
        ckpt_q[ckpt_id_in] <= rd_adv;
      end
    end
  end

  // Commit can never hand back more tags than were taken out.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(rel_do && full));

endmodule
